// File: rtl/button_pynq.sv
`default_nettype none
// ============================================================================
// Module   : button_pynq
// Brief    : Push-button sampler with programmable debounce, sticky press
//            flags and per-button press counters for PS register readback.
// Revision : 1.0 - initial release
// ============================================================================
module button_pynq #(
  parameter int NBTN = 4,
  parameter int CNTW = 16
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [NBTN-1:0]      BTN,
  input  logic [31:0]          DEBOUNCE,
  input  logic [NBTN-1:0]      CLR,
  output logic [NBTN-1:0]      STATE,
  output logic [NBTN-1:0]      PRESS,
  output logic [NBTN*CNTW-1:0] COUNTS
);

  logic [NBTN-1:0] r_s1;
  logic [NBTN-1:0] r_s2;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= BTN;
      r_s2 <= r_s1;
    end
  end

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    logic [31:0]     r_dcnt;
    logic            r_state;
    logic            r_press;
    logic [CNTW-1:0] r_count;
    logic            w_diff;
    logic            w_accept;
    logic            w_press_evt;

    assign w_diff      = r_s2[gi] ^ r_state;
    // Compare against the live threshold so a lowered DEBOUNCE takes effect at once.
    assign w_accept    = w_diff && (r_dcnt >= DEBOUNCE);
    assign w_press_evt = w_accept && r_s2[gi];

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        r_dcnt  <= '0;
        r_state <= 1'b0;
        r_press <= 1'b0;
        r_count <= '0;
      end else begin
        if (!w_diff) begin
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_state <= r_s2[gi];
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + 32'd1;
        end

        // A press landing on the same edge as a clear must not be lost.
        if (w_press_evt) begin
          r_press <= 1'b1;
        end else if (CLR[gi]) begin
          r_press <= 1'b0;
        end

        if (w_press_evt) begin
          r_count <= r_count + CNTW'(1);
        end
      end
    end

    assign STATE[gi]                 = r_state;
    assign PRESS[gi]                 = r_press;
    assign COUNTS[gi*CNTW +: CNTW]   = r_count;
  end

endmodule
`default_nettype wire

// File: doc/button_pynq.md
# button_pynq

Input-side companion to the LED blinker: samples the board push buttons, debounces them with a PS-programmable stability threshold, and reports debounced level, sticky press flags and per-button press counters back to the PS through AXI GPIO-style registers. Sits between the board button pins and the PS register interface, clocked by the fabric clock.

## Interface
- NBTN, 4, number of buttons
- CNTW, 16, width of each press counter
- CLK  input  1  fabric clock; all state updates on rising edge
- RESETN  input  1  asynchronous, active-low reset
- BTN  input  NBTN  raw button pins, asynchronous to CLK, 1 = pressed
- DEBOUNCE  input  32  stability threshold in CLK cycles (PS register)
- CLR  input  NBTN  per-button clear of PRESS, level-sampled each cycle
- STATE  output  NBTN  debounced button level
- PRESS  output  NBTN  sticky flag, set on each debounced press
- COUNTS  output  NBTN*CNTW  packed press counters, button i at bits [i*CNTW +: CNTW]

## Operation
- Reset (RESETN low, any time, asynchronous): synchronizer flops, debounce counters, STATE, PRESS, COUNTS all 0. Operation resumes on the first rising edge after RESETN is high.
- Synchronizer: two-flop chain per bit, BTN -> s1 -> s2. Only s2 is used downstream.
- Debounce, per button i, 32-bit counter d[i]:
  - s2[i] == STATE[i]: d[i] <= 0.
  - s2[i] != STATE[i] and d[i] >= DEBOUNCE: STATE[i] <= s2[i], d[i] <= 0.
  - s2[i] != STATE[i] and d[i] < DEBOUNCE: d[i] <= d[i] + 1.
  - Net effect: a new level is accepted after DEBOUNCE+1 consecutive mismatching cycles of s2; any single matching cycle restarts the count.
  - DEBOUNCE = 0: accept on the first mismatch cycle (no filtering).
  - DEBOUNCE changed mid-count: the comparison always uses the current value; if d[i] already >= new value, accept on the next mismatch cycle.
  - Comparison unsigned, 32 bits; d[i] never exceeds DEBOUNCE so it cannot wrap.
- Press event: cycle in which STATE[i] goes 0 -> 1 (the accept edge). Releases (1 -> 0) generate no event.
- PRESS[i]: set on press event; cleared when CLR[i] = 1 at a clock edge. Set and clear at the same edge: set wins (no lost event). CLR has no effect on STATE or COUNTS.
- COUNTS[i]: increments by 1 on each press event, modulo 2^CNTW (all-ones wraps to 0, no saturation). Only cleared by reset.
- Buttons are fully independent; simultaneous events on several buttons are all recorded in the same cycle.

## Timing
- BTN change captured into s1 at edge E0, s2 at E1; with a clean input, STATE updates at edge E1 + DEBOUNCE + 1, i.e. DEBOUNCE+2 edges after E0.
- PRESS and COUNTS update on the same edge as STATE (registered together, zero extra latency).
- CLR effect visible one edge after it is sampled high.
- All outputs are direct flop outputs; no combinational path from any input to any output.

## Test plan
- Reset: drive BTN=4'b1111, assert RESETN low mid-operation without a clock edge -> STATE, PRESS, COUNTS read 0 immediately; hold released -> remain 0.
- Clean press: DEBOUNCE=3, BTN[0] 0->1 sampled at E0 -> STATE[0]=1, PRESS[0]=1, COUNTS[0]=1 after edge E0+5, not before; release after stable 1 -> STATE[0]=0 with no PRESS/COUNTS change.
- Bounce: DEBOUNCE=10, BTN[1] toggles every 4 cycles for 40 cycles then settles at 1 -> exactly one press event, COUNTS[1]=1, accepted 12 edges after the final toggle.
- Clear race: PRESS[2]=1, assert CLR[2] on the same edge as a new press of button 2 -> PRESS[2] stays 1, COUNTS[2] increments; CLR[2] alone next cycle -> PRESS[2]=0.
- Wrap and zero threshold: CNTW=4, DEBOUNCE=0, 16 clean presses on BTN[3] -> COUNTS[3] goes 15 -> 0, each accepted 2 edges after capture.
- Threshold change: DEBOUNCE=100, hold mismatch 50 cycles, write DEBOUNCE=20 -> STATE accepts on the next edge; all four buttons pressed together -> PRESS=4'b1111, each counter +1 in the same cycle.
